// File: rtl/imem_loader.sv
// imem_loader: receives a program image as a byte stream (HDR, words, CSUM),
// packs bytes into 32-bit instructions, writes them into instruction memory from
// address 0 upward, verifies an XOR checksum and holds the CPU until the image
// is complete and verified. All outputs are registered.
module imem_loader #(
  parameter int ADDR_W     = 8,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_DATA,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  // Highest legal word address; header counts beyond the memory depth clamp to it.
  localparam logic [63:0] LAST_MAX64 = (64'd1 << ADDR_W) - 64'd1;
  localparam logic [31:0] LAST_MAX   = LAST_MAX64[31:0];

  state_t              state, state_next;
  logic [1:0]          byte_cnt;
  logic [ADDR_W-1:0]   last_addr;
  logic [ADDR_W-1:0]   hdr_last;
  logic [7:0]          csum;
  logic [31:0]         word_shifted;
  logic [31:0]         hdr_ext;
  logic                accept;

  // A byte transfers only when the loader has advertised ready.
  assign accept  = byte_valid & byte_ready;
  assign hdr_ext = {24'd0, byte_in};

  // Header byte is (word count - 1); convert it to a clamped last address.
  always_comb begin
    hdr_last = hdr_ext[ADDR_W-1:0];
    if (hdr_ext > LAST_MAX) begin
      hdr_last = LAST_MAX[ADDR_W-1:0];
    end
  end

  // Byte order inside a word is fixed at elaboration time.
  generate
    if (BIG_ENDIAN) begin : g_big
      assign word_shifted = {imem_wdata[23:0], byte_in};
    end else begin : g_little
      assign word_shifted = {byte_in, imem_wdata[31:8]};
    end
  endgenerate

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) state_next = S_HEADER;
      end
      S_HEADER: begin
        if (accept) state_next = S_DATA;
      end
      S_DATA: begin
        if (accept && (byte_cnt == 2'd3)) state_next = S_WRITE;
      end
      S_WRITE: begin
        state_next = (imem_addr == last_addr) ? S_CHECK : S_DATA;
      end
      S_CHECK: begin
        if (accept) state_next = (byte_in == csum) ? S_DONE : S_ERROR;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State register plus status outputs registered from the next state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      byte_ready <= 1'b0;
      imem_we    <= 1'b0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state      <= state_next;
      byte_ready <= (state_next == S_HEADER) || (state_next == S_DATA) ||
                    (state_next == S_CHECK);
      imem_we    <= (state_next == S_WRITE);
      cpu_hold   <= (state_next != S_DONE);
      done       <= (state_next == S_DONE);
      error      <= (state_next == S_ERROR);
    end
  end

  // Datapath: word assembly, checksum, byte counter and write address.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      byte_cnt   <= 2'd0;
      last_addr  <= '0;
      csum       <= 8'd0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
    end else begin
      case (state)
        S_HEADER: begin
          if (accept) begin
            last_addr <= hdr_last;
            imem_addr <= '0;
            csum      <= 8'd0;
            byte_cnt  <= 2'd0;
          end
        end
        S_DATA: begin
          if (accept) begin
            imem_wdata <= word_shifted;
            csum       <= csum ^ byte_in;
            byte_cnt   <= byte_cnt + 2'd1;
          end
        end
        S_WRITE: begin
          // Address advances only between words, so it never wraps.
          if (imem_addr != last_addr) imem_addr <= imem_addr + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: drives byte-stream images into a big-endian and a
// little-endian loader sharing the same inputs, and compares memory writes and
// status against a reference built directly from the stream format.
module tb_imem_loader;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;

  logic        be_ready, be_we, be_hold, be_done, be_error;
  logic [7:0]  be_addr;
  logic [31:0] be_wdata;
  logic        le_ready, le_we, le_hold, le_done, le_error;
  logic [7:0]  le_addr;
  logic [31:0] le_wdata;

  int checks = 0;
  int errors = 0;
  int ready_viol = 0;
  wr_t be_wr[$];
  wr_t le_wr[$];

  always #5 clock = ~clock;

  imem_loader #(.ADDR_W(8), .BIG_ENDIAN(1'b1)) dut_be (
    .clock(clock), .reset_n(reset_n), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(be_ready), .imem_we(be_we),
    .imem_addr(be_addr), .imem_wdata(be_wdata), .cpu_hold(be_hold),
    .done(be_done), .error(be_error)
  );

  imem_loader #(.ADDR_W(8), .BIG_ENDIAN(1'b0)) dut_le (
    .clock(clock), .reset_n(reset_n), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(le_ready), .imem_we(le_we),
    .imem_addr(le_addr), .imem_wdata(le_wdata), .cpu_hold(le_hold),
    .done(le_done), .error(le_error)
  );

  // Record every memory write, sampled mid-cycle.
  always @(negedge clock) begin
    if (reset_n) begin
      if (be_we) begin
        be_wr.push_back('{be_addr, be_wdata});
        if (be_ready) ready_viol++;
      end
      if (le_we) begin
        le_wr.push_back('{le_addr, le_wdata});
        if (le_ready) ready_viol++;
      end
    end
  end

  // Offer one byte after an optional idle gap and hold it until accepted.
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap;
    int waited;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    repeat (gap) @(negedge clock);
    byte_in    = b;
    byte_valid = 1'b1;
    waited     = 0;
    while (!be_ready && waited < 64) begin
      @(negedge clock);
      waited++;
    end
    checks++;
    if (!be_ready) begin
      errors++;
      $display("FAIL send_byte_timeout byte=%02h ready=%0b required=1", b, be_ready);
      byte_valid = 1'b0;
    end else begin
      @(negedge clock);
      byte_valid = 1'b0;
      byte_in    = 8'($urandom);
    end
  endtask

  // Start a load, stream it, then compare writes and status to the reference.
  task automatic run_load(input string tag, input logic [7:0] hdr, input bq_t data,
                          input logic [7:0] csum_byte, input int max_gap,
                          input int start_at);
    int nwords;
    logic [7:0]  exp_xor;
    logic [31:0] exp_be, exp_le;
    bit good;
    be_wr.delete();
    le_wr.delete();
    ready_viol = 0;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    checks++;
    if (be_done !== 1'b0 || be_error !== 1'b0 || be_hold !== 1'b1) begin
      errors++;
      $display("FAIL %s_start_status done=%0b error=%0b hold=%0b required 0 0 1",
               tag, be_done, be_error, be_hold);
    end
    send_byte(hdr, max_gap);
    for (int i = 0; i < data.size(); i++) begin
      if (i == start_at) begin
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
      end
      send_byte(data[i], max_gap);
    end
    send_byte(csum_byte, max_gap);
    repeat (2) @(negedge clock);

    nwords  = int'(hdr) + 1;
    exp_xor = 8'd0;
    foreach (data[i]) exp_xor ^= data[i];
    good = (csum_byte == exp_xor);

    checks++;
    if (be_wr.size() != nwords || le_wr.size() != nwords) begin
      errors++;
      $display("FAIL %s_write_count be=%0d le=%0d required=%0d",
               tag, be_wr.size(), le_wr.size(), nwords);
    end
    for (int w = 0; w < nwords && w < be_wr.size() && w < le_wr.size(); w++) begin
      exp_be = {data[4*w], data[4*w+1], data[4*w+2], data[4*w+3]};
      exp_le = {data[4*w+3], data[4*w+2], data[4*w+1], data[4*w]};
      checks++;
      if (be_wr[w].addr !== 8'(w) || be_wr[w].data !== exp_be) begin
        errors++;
        $display("FAIL %s_be_word%0d addr=%0d data=%08h required addr=%0d data=%08h",
                 tag, w, be_wr[w].addr, be_wr[w].data, w, exp_be);
      end
      checks++;
      if (le_wr[w].addr !== 8'(w) || le_wr[w].data !== exp_le) begin
        errors++;
        $display("FAIL %s_le_word%0d addr=%0d data=%08h required addr=%0d data=%08h",
                 tag, w, le_wr[w].addr, le_wr[w].data, w, exp_le);
      end
    end
    checks++;
    if (ready_viol != 0) begin
      errors++;
      $display("FAIL %s_ready_in_write count=%0d required=0", tag, ready_viol);
    end
    checks++;
    if (be_done !== good || be_error !== !good || be_hold !== !good ||
        le_done !== good || le_error !== !good) begin
      errors++;
      $display("FAIL %s_status done=%0b error=%0b hold=%0b required %0b %0b %0b",
               tag, be_done, be_error, be_hold, good, !good, !good);
    end
    $display("load %s: hdr=%02h words=%0d csum=%02h expect_%s writes=%0d",
             tag, hdr, nwords, csum_byte, good ? "done" : "error", be_wr.size());
  endtask

  function automatic bq_t rand_data(input int nwords);
    bq_t q;
    for (int i = 0; i < 4 * nwords; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  function automatic logic [7:0] xor_of(input bq_t q);
    logic [7:0] x = 8'd0;
    foreach (q[i]) x ^= q[i];
    return x;
  endfunction

  task automatic test_reset();
    bq_t q;
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if (be_ready !== 1'b0 || be_we !== 1'b0 || be_addr !== 8'd0 || be_wdata !== 32'd0 ||
        be_hold !== 1'b1 || be_done !== 1'b0 || be_error !== 1'b0) begin
      errors++;
      $display("FAIL reset_state ready=%0b we=%0b addr=%0d wdata=%08h hold=%0b done=%0b error=%0b required 0 0 0 0 1 0 0",
               be_ready, be_we, be_addr, be_wdata, be_hold, be_done, be_error);
    end
    reset_n = 1'b1;
    @(negedge clock);
    // Abort a load while a write pulse is active.
    q = rand_data(4);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    send_byte(8'd3, 0);
    for (int i = 0; i < 4; i++) send_byte(q[i], 0);
    checks++;
    if (be_we !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_we we=%0b required=1", be_we);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (be_we !== 1'b0 || be_hold !== 1'b1 || be_done !== 1'b0 ||
        be_error !== 1'b0 || be_ready !== 1'b0 || be_addr !== 8'd0) begin
      errors++;
      $display("FAIL reset_async we=%0b hold=%0b done=%0b error=%0b ready=%0b addr=%0d required 0 1 0 0 0 0",
               be_we, be_hold, be_done, be_error, be_ready, be_addr);
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    $display("reset test complete");
  endtask

  task automatic test_one_word();
    bq_t q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_load("one_word", 8'h00, q, 8'h22, 0, -1);
    checks++;
    if (be_wr.size() != 1 || be_wr[0].data !== 32'hDEADBEEF || be_done !== 1'b1 ||
        be_hold !== 1'b0) begin
      errors++;
      $display("FAIL one_word_literal writes=%0d done=%0b hold=%0b required 1 DEADBEEF 1 0",
               be_wr.size(), be_done, be_hold);
    end
  endtask

  task automatic test_bad_checksum();
    bq_t q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    bq_t r;
    run_load("bad_csum", 8'h00, q, 8'h23, 0, -1);
    checks++;
    if (be_error !== 1'b1 || be_done !== 1'b0 || be_hold !== 1'b1) begin
      errors++;
      $display("FAIL bad_csum_literal error=%0b done=%0b hold=%0b required 1 0 1",
               be_error, be_done, be_hold);
    end
    r = rand_data(2);
    run_load("recover", 8'h01, r, xor_of(r), 1, -1);
  endtask

  task automatic test_backpressure();
    bq_t q;
    for (int k = 0; k < 6; k++) begin
      int nw = (k == 0) ? 3 : int'($urandom_range(6, 1));
      logic [7:0] cs;
      q  = rand_data(nw);
      cs = xor_of(q);
      if (k % 3 == 2) cs = cs ^ 8'(1 << $urandom_range(7, 0));
      run_load($sformatf("gaps%0d", k), 8'(nw - 1), q, cs, 4, -1);
    end
  endtask

  task automatic test_full_depth();
    bq_t q = rand_data(256);
    run_load("full_depth", 8'hFF, q, xor_of(q), 0, -1);
    checks++;
    if (be_wr.size() == 0 || be_wr[be_wr.size()-1].addr !== 8'd255 || be_addr !== 8'd255) begin
      errors++;
      $display("FAIL full_depth_last_addr writes=%0d addr=%0d required last=255",
               be_wr.size(), be_addr);
    end
  endtask

  task automatic test_little_endian();
    bq_t q = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_load("little_endian", 8'h00, q, 8'h04, 0, 2);
    checks++;
    if (le_wr.size() != 1 || le_wr[0].data !== 32'h04030201 || le_done !== 1'b1) begin
      errors++;
      $display("FAIL little_endian_literal writes=%0d done=%0b required 1 04030201 1",
               le_wr.size(), le_done);
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    start      = 1'b0;
    byte_in    = 8'd0;
    byte_valid = 1'b0;
    test_reset();
    test_one_word();
    test_bad_checksum();
    test_backpressure();
    test_full_depth();
    test_little_endian();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
